// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The overflow signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;
`endif

`ifdef SERIAL_SUB_OVERFLOW_EN
  modport master (output start, a, b, bin, input busy, done, diff, borrow_out, overflow);
  modport slave  (input start, a, b, bin, output busy, done, diff, borrow_out, overflow);
`else
  modport master (output start, a, b, bin, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, bin, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clk through a full-subtractor cell.
// Optional signed overflow flag enabled by the macro SERIAL_SUB_OVERFLOW_EN.
//
// state | meaning
// IDLE  | waiting for start, result registers hold last completion
// SHIFT | one operand bit pair consumed per cycle, borrow kept in brw
// DONE  | done pulse cycle, returns to IDLE unconditionally
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             x, y, d, bo;
  logic             busy_r, done_r, bo_r;
  logic [WIDTH-1:0] diff_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ops_differ;
  logic             ov_r;
`endif

  // Full-subtractor cell on the current LSBs and the held borrow.
  assign x        = a_sh[0];
  assign y        = b_sh[0];
  assign d        = x ^ y ^ brw;
  assign bo       = (~x & y) | (~(x ^ y) & brw);
  assign res_next = {d, res_sh};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, bit stepping, result load and registered status.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_r <= '0;
      bo_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ops_differ <= 1'b0;
      ov_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            brw  <= bus.bin;
            cnt  <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ops_differ <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          res_sh <= res_next[WIDTH-1:1];
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          brw    <= bo;
          if (cnt == CNT_LAST) begin
            // On the last step x is the captured a MSB.
            diff_r <= res_next;
            bo_r   <= bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ov_r   <= ops_differ && (d != x);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
      busy_r <= (state_nxt == SHIFT);
      done_r <= (state_nxt == DONE);
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.diff       = diff_r;
  assign bus.borrow_out = bo_r;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.overflow   = ov_r;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, hand
// sequences for the multi-cycle cases, and randomized ops against a model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) ifc ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bo;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain (W+1)-bit arithmetic and signed range test.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] r;
    r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    return r;
  endfunction

  function automatic logic ref_ov(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = sa - sb - int'(bin);
    return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic ebo);
    int nbusy, ndone;
    nbusy = 0;
    ndone = 0;
    ifc.start = 1'b1;
    ifc.a     = a;
    ifc.b     = b;
    ifc.bin   = bin;
    tick();
    ifc.start = 1'b0;
    ifc.a     = W'($urandom);
    ifc.b     = W'($urandom);
    ifc.bin   = 1'($urandom);
    for (int k = 0; k < W; k++) begin
      nbusy += int'(ifc.busy);
      ndone += int'(ifc.done);
      tick();
    end
    check("busy_cycles", nbusy, W);
    check("early_done", ndone, 0);
    check("done_pulse", ifc.done, 1);
    check("busy_at_done", ifc.busy, 0);
    check("diff", ifc.diff, ed);
    check("borrow_out", ifc.borrow_out, ebo);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("overflow", ifc.overflow, ref_ov(a, b, bin));
`endif
    tick();
    check("done_one_cycle", ifc.done, 0);
    check("diff_held", ifc.diff, ed);
  endtask

  initial begin
    logic [W:0] r;
    logic [W-1:0] ra, rb;
    logic rbin;
    int ndone, acc, last_c;
    logic prev_busy;
    logic [W-1:0] ha[3];
    logic [W-1:0] hb[3];
    logic [W-1:0] hd[3];
    logic         hbo[3];

    vecs[0] = '{8'h0A, 8'h03, 1'b0, 8'h07, 1'b0};
    vecs[1] = '{8'h03, 8'h0A, 1'b0, 8'hF9, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1};

    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    ifc.bin = 1'b0;
    tick();
    tick();
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_diff", ifc.diff, 0);
    check("rst_borrow", ifc.borrow_out, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("rst_overflow", ifc.overflow, 0);
`endif

    // Reset wins over a simultaneous start.
    ifc.start = 1'b1;
    ifc.a = 8'h12;
    tick();
    rst = 1'b0;
    ifc.start = 1'b0;
    tick();
    check("rst_start_busy", ifc.busy, 0);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bo);

    // Second start during SHIFT is ignored.
    ifc.start = 1'b1;
    ifc.a = 8'h55;
    ifc.b = 8'h11;
    ifc.bin = 1'b0;
    tick();
    ifc.start = 1'b0;
    tick();
    tick();
    ifc.start = 1'b1;
    ifc.a = 8'hFF;
    ifc.b = 8'h00;
    tick();
    ifc.start = 1'b0;
    ndone = 0;
    for (int c = 0; c < 14; c++) begin
      ndone += int'(ifc.done);
      tick();
    end
    check("ignored_start_dones", ndone, 1);
    check("ignored_start_diff", ifc.diff, 8'h44);
    check("ignored_start_busy", ifc.busy, 0);

    // Reset four cycles into an op.
    ifc.start = 1'b1;
    ifc.a = 8'hF0;
    ifc.b = 8'h0F;
    tick();
    ifc.start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", ifc.busy, 0);
    check("midrst_diff", ifc.diff, 0);
    check("midrst_done", ifc.done, 0);
    check("midrst_borrow", ifc.borrow_out, 0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      ndone += int'(ifc.done);
      tick();
    end
    check("midrst_no_done", ndone, 0);
    run_op(8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0);

    // start held high: three back-to-back ops.
    ha[0] = 8'h10; hb[0] = 8'h01; hd[0] = 8'h0F; hbo[0] = 1'b0;
    ha[1] = 8'h01; hb[1] = 8'h02; hd[1] = 8'hFF; hbo[1] = 1'b1;
    ha[2] = 8'h80; hb[2] = 8'h80; hd[2] = 8'h00; hbo[2] = 1'b0;
    acc = 0;
    ndone = 0;
    last_c = 0;
    prev_busy = 1'b0;
    ifc.start = 1'b1;
    ifc.a = ha[0];
    ifc.b = hb[0];
    ifc.bin = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ifc.busy && !prev_busy) begin
        acc++;
        if (acc < 3) begin
          ifc.a = ha[acc];
          ifc.b = hb[acc];
        end else begin
          ifc.start = 1'b0;
        end
      end
      prev_busy = ifc.busy;
      if (ifc.done) begin
        if (ndone < 3) begin
          check("b2b_diff", ifc.diff, hd[ndone]);
          check("b2b_borrow", ifc.borrow_out, hbo[ndone]);
        end
        if (ndone > 0) check("b2b_spacing", c - last_c, W + 2);
        last_c = c;
        ndone++;
      end
    end
    ifc.start = 1'b0;
    check("b2b_dones", ndone, 3);

`ifdef SERIAL_SUB_OVERFLOW_EN
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    check("ov_set", ifc.overflow, 1);
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    check("ov_clear", ifc.overflow, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      r    = ref_sub(ra, rb, rbin);
      run_op(ra, rb, rbin, r[W-1:0], r[W]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
